// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side blocks.
// Holds the default word width, read FSM states and the word type.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } rd_state_e;

  typedef logic [DATA_W_DEF-1:0] fifo_word_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Small circular store between the FIFO read port and the stream.
// Ports: clk, rst_n, push/din in, pop in, head/occ out.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [AW:0]       occ
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign occ  = cnt;

endmodule

// File: rtl/fifo_rd_engine.sv
// Read-side FIFO consumer: fetch control, skid store, framed stream.
// Ports: FIFO read port, valid/ready stream, word_cnt, stall_err.
module fifo_rd_engine
  import fifo_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BUF_DEPTH   = 4,
  parameter int BURST_LEN   = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic [15:0]       word_cnt,
  output logic              stall_err
);

  localparam int OW = $clog2(BUF_DEPTH) + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BW-1:0] BP_LAST = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] WD_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [OW:0]   OCC_LIM = (OW + 1)'(BUF_DEPTH);

  rd_state_e         state;
  rd_state_e         nxt;
  logic              inflight;
  logic              xfer;
  logic              wd_run;
  logic [OW-1:0]     occ;
  logic [OW:0]       pend;
  logic [DATA_W-1:0] head;
  logic [BW-1:0]     burst_pos;
  logic [TW-1:0]     wd_cnt;

  rd_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk   (rd_clk),
    .rst_n (rd_rst),
    .push  (inflight),
    .din   (fifo_rd_data),
    .pop   (xfer),
    .head  (head),
    .occ   (occ)
  );

  // Reserve store space for the word already on its way.
  assign pend = {1'b0, occ} + {{OW{1'b0}}, inflight};

  assign fifo_rd_en = enable && !fifo_empty &&
                      (state == STREAM) && (pend < OCC_LIM);

  assign m_valid = (occ != '0);
  assign xfer    = m_valid && m_ready;
  assign m_data  = m_valid ? head : '0;
  assign m_last  = m_valid && (burst_pos == BP_LAST);
  assign busy    = (state != IDLE);

  assign wd_run = (state == STREAM) && (burst_pos != '0) && !xfer;

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (enable) nxt = STREAM;
      end
      STREAM: begin
        if (!enable) nxt = DRAIN;
      end
      DRAIN: begin
        if (enable) begin
          nxt = STREAM;
        end else if (occ == '0 && !inflight) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Read data arrives exactly one cycle after the pop request.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      word_cnt  <= '0;
      burst_pos <= '0;
      wd_cnt    <= '0;
      stall_err <= 1'b0;
    end else if (clear) begin
      word_cnt  <= '0;
      burst_pos <= '0;
      wd_cnt    <= '0;
      stall_err <= 1'b0;
    end else begin
      if (xfer) begin
        word_cnt  <= word_cnt + 16'd1;
        burst_pos <= (burst_pos == BP_LAST) ? '0 : burst_pos + 1'b1;
        wd_cnt    <= '0;
      end else if (wd_run) begin
        if (wd_cnt == WD_LAST) stall_err <= 1'b1;
        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

endmodule
